// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//
// Purpose: sequences single (or, optionally, burst) load/store accesses from
// the core to a data memory. A request is accepted in IDLE, a load holds
// memread for MEM_LATENCY cycles and captures mem_rdata on the last one, a
// store pulses memwrite for one cycle, and every beat ends with a one-cycle
// rsp_valid pulse.
//
// Handshake: a request transfers on a rising edge where req_valid=1 and
// req_ready=1. req_ready is 1 only in IDLE. The core does not have to hold
// req_valid. Requests presented while busy are dropped, not queued.
// rsp_valid is a single-cycle pulse with no back-pressure.
//
// Parameters:
//   MEM_LATENCY  read cycles per load beat (1..15; 0 is treated as 1)
//
// Optional feature (macro LSU_BURST_EN):
//   Adds input req_len. A request then runs req_len+1 beats. The address
//   increments by one per beat and wraps at 0xFF. A store burst writes the
//   same data to every beat.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req_valid/req_ready   request handshake
//   req_write             1 = store, 0 = load
//   req_addr, req_wdata   access address and store data
//   req_len               burst length - 1 (LSU_BURST_EN only)
//   rsp_valid, rsp_rdata  completion pulse and last load result
//   alu_result_address    address to data memory
//   write_data            data to data memory
//   memread, memwrite     memory strobes
//   memory_to_register    memory mux select (equals memread)
//   mem_rdata             read data from memory
//   fsm_state             current FSM state (IDLE=0 READ=1 WRITE=2 RESP=3)
// ---------------------------------------------------------------------------
module load_store_unit #(
  parameter int MEM_LATENCY = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic       req_write,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
`ifdef LSU_BURST_EN
  input  logic [3:0] req_len,
`endif
  output logic       req_ready,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic [7:0] alu_result_address,
  output logic [7:0] write_data,
  output logic       memread,
  output logic       memwrite,
  output logic       memory_to_register,
  input  logic [7:0] mem_rdata,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Zero behaves as one; values above 16 do not fit the 4-bit counter.
  localparam int LAT_EFF = (MEM_LATENCY < 1) ? 1 :
                           ((MEM_LATENCY > 16) ? 16 : MEM_LATENCY);
  localparam logic [3:0] LAST_CNT = 4'(LAT_EFF - 1);

  state_t     state, state_n;
  logic [3:0] cnt;
  logic [3:0] beats_left;
  logic [7:0] addr_q;
  logic [7:0] wdata_q;
  logic       write_q;
  logic [7:0] rdata_q;
  logic       accept;
  logic [3:0] len_in;

`ifdef LSU_BURST_EN
  assign len_in = req_len;
`else
  assign len_in = 4'd0;
`endif

  assign accept = (state == IDLE) && req_valid;

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (req_valid) state_n = req_write ? WRITE : READ;
      READ:    if (cnt == LAST_CNT) state_n = RESP;
      WRITE:   state_n = RESP;
      RESP:    if (beats_left != 4'd0) state_n = write_q ? WRITE : READ;
               else state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are decoded from state only.
  always_comb begin
    req_ready          = 1'b0;
    rsp_valid          = 1'b0;
    memread            = 1'b0;
    memwrite           = 1'b0;
    memory_to_register = 1'b0;
    case (state)
      IDLE:    req_ready = 1'b1;
      READ:    begin
                 memread            = 1'b1;
                 memory_to_register = 1'b1;
               end
      WRITE:   memwrite = 1'b1;
      RESP:    rsp_valid = 1'b1;
      default: req_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      beats_left <= 4'd0;
      addr_q     <= 8'h00;
      wdata_q    <= 8'h00;
      write_q    <= 1'b0;
      rdata_q    <= 8'h00;
    end else begin
      state <= state_n;
      if (accept) begin
        addr_q     <= req_addr;
        wdata_q    <= req_wdata;
        write_q    <= req_write;
        cnt        <= 4'd0;
        beats_left <= len_in;
      end
      if (state == READ) begin
        if (cnt == LAST_CNT) begin
          rdata_q <= mem_rdata;
          cnt     <= 4'd0;
        end else begin
          cnt <= cnt + 4'd1;
        end
      end
      // Advance to the next beat; 8-bit add wraps 0xFF to 0x00.
      if (state == RESP && beats_left != 4'd0) begin
        beats_left <= beats_left - 4'd1;
        addr_q     <= addr_q + 8'd1;
        cnt        <= 4'd0;
      end
    end
  end

  assign rsp_rdata          = rdata_q;
  assign alu_result_address = addr_q;
  assign write_data         = wdata_q;
  assign fsm_state          = state;

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
//
// Directed bench for load_store_unit built with MEM_LATENCY=3. A small
// behavioural data memory (mem[i] = ~i initially, updated on memwrite)
// feeds mem_rdata. Burst vectors are compiled only with LSU_BURST_EN.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

  localparam int LAT = 3;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       req_valid;
  logic       req_write;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic [3:0] req_len;
  logic       req_ready;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic [7:0] alu_result_address;
  logic [7:0] write_data;
  logic       memread;
  logic       memwrite;
  logic       memory_to_register;
  logic [7:0] mem_rdata;
  logic [1:0] fsm_state;

  load_store_unit #(.MEM_LATENCY(LAT)) dut (
    .clk                (clk),
    .reset              (reset),
    .req_valid          (req_valid),
    .req_write          (req_write),
    .req_addr           (req_addr),
    .req_wdata          (req_wdata),
`ifdef LSU_BURST_EN
    .req_len            (req_len),
`endif
    .req_ready          (req_ready),
    .rsp_valid          (rsp_valid),
    .rsp_rdata          (rsp_rdata),
    .alu_result_address (alu_result_address),
    .write_data         (write_data),
    .memread            (memread),
    .memwrite           (memwrite),
    .memory_to_register (memory_to_register),
    .mem_rdata          (mem_rdata),
    .fsm_state          (fsm_state)
  );

  // Behavioural data memory
  logic [7:0] mem [256];
  initial for (int i = 0; i < 256; i++) mem[i] = ~8'(i);
  always @(posedge clk) if (memwrite) mem[alu_result_address] <= write_data;
  assign mem_rdata = mem[alu_result_address];

  // Response pulse monitor
  int rsp_count = 0;
  always @(posedge clk) if (rsp_valid) rsp_count <= rsp_count + 1;

  // Scoreboard counters
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input logic [7:0] a, input logic [7:0] d);
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d;
    tick();
    req_valid = 1'b0;
    check("st_state_write", 16'(fsm_state), 16'd2);
    check("st_memwrite",    16'(memwrite), 16'd1);
    check("st_memread",     16'(memread), 16'd0);
    check("st_addr",        16'(alu_result_address), 16'(a));
    check("st_wdata",       16'(write_data), 16'(d));
    check("st_ready_busy",  16'(req_ready), 16'd0);
    tick();
    check("st_memwrite_off", 16'(memwrite), 16'd0);
    check("st_rsp_valid",    16'(rsp_valid), 16'd1);
    tick();
    check("st_ready_back",   16'(req_ready), 16'd1);
    check("st_rsp_off",      16'(rsp_valid), 16'd0);
  endtask

  task automatic do_load(input logic [7:0] a, input logic [7:0] exp_d);
    req_valid = 1'b1; req_write = 1'b0; req_addr = a;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      check("ld_memread", 16'(memread), 16'd1);
      check("ld_m2r",     16'(memory_to_register), 16'd1);
      check("ld_memwrite",16'(memwrite), 16'd0);
      check("ld_addr",    16'(alu_result_address), 16'(a));
      check("ld_ready",   16'(req_ready), 16'd0);
      tick();
    end
    check("ld_rsp_valid", 16'(rsp_valid), 16'd1);
    check("ld_rdata",     16'(rsp_rdata), 16'(exp_d));
    check("ld_memread_off", 16'(memread), 16'd0);
    check("ld_m2r_off",   16'(memory_to_register), 16'd0);
    tick();
    check("ld_ready_back", 16'(req_ready), 16'd1);
    check("ld_rsp_off",    16'(rsp_valid), 16'd0);
  endtask

  int rc0;

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    req_addr = 8'h00; req_wdata = 8'h00; req_len = 4'd0;
    tick();
    tick();
    check("rst_ready",  16'(req_ready), 16'd1);
    check("rst_rsp",    16'(rsp_valid), 16'd0);
    check("rst_rdata",  16'(rsp_rdata), 16'h00);
    check("rst_addr",   16'(alu_result_address), 16'h00);
    check("rst_wdata",  16'(write_data), 16'h00);
    check("rst_mrd",    16'(memread), 16'd0);
    check("rst_mwr",    16'(memwrite), 16'd0);
    check("rst_m2r",    16'(memory_to_register), 16'd0);
    check("rst_state",  16'(fsm_state), 16'd0);
    reset = 1'b0;
    tick();

    // Store 0x10 <- 0xA5, then load it back.
    do_store(8'h10, 8'hA5);
    do_load(8'h10, 8'hA5);

    // A store leaves the last load result untouched.
    do_store(8'h20, 8'h5A);
    check("rdata_held_after_store", 16'(rsp_rdata), 16'hA5);
    do_load(8'h20, 8'h5A);
    do_load(8'hFF, 8'h00);
    do_load(8'h00, 8'hFF);

    // req_valid held high through a load: only one access in flight.
    rc0 = rsp_count;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h30;
    tick();
    for (int i = 0; i < LAT; i++) begin
      check("hold_memread", 16'(memread), 16'd1);
      check("hold_ready",   16'(req_ready), 16'd0);
      tick();
    end
    check("hold_rsp",     16'(rsp_valid), 16'd1);
    check("hold_rdata",   16'(rsp_rdata), 16'hCF);
    check("hold_ready_resp", 16'(req_ready), 16'd0);
    check("hold_no_mrd_resp", 16'(memread), 16'd0);
    tick();
    check("hold_ready_idle", 16'(req_ready), 16'd1);
    check("hold_idle_mrd",   16'(memread), 16'd0);
    tick();
    req_valid = 1'b0;
    check("hold_second_mrd", 16'(memread), 16'd1);
    for (int i = 0; i < LAT; i++) tick();
    check("hold_second_rsp", 16'(rsp_valid), 16'd1);
    tick();
    check("hold_rsp_count", 16'(rsp_count - rc0), 16'd2);

    // Reset on the second READ cycle aborts the load.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h40;
    tick();
    req_valid = 1'b0;
    check("abort_rd1", 16'(memread), 16'd1);
    tick();
    check("abort_rd2", 16'(memread), 16'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_mrd",   16'(memread), 16'd0);
    check("abort_ready", 16'(req_ready), 16'd1);
    check("abort_rsp",   16'(rsp_valid), 16'd0);
    check("abort_rdata", 16'(rsp_rdata), 16'h00);
    check("abort_state", 16'(fsm_state), 16'd0);
    rc0 = rsp_count;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("abort_quiet_mrd", 16'(memread), 16'd0);
    end
    check("abort_no_rsp", 16'(rsp_count - rc0), 16'd0);

    // Reset wins over a simultaneous request.
    reset = 1'b1; req_valid = 1'b1; req_write = 1'b1;
    req_addr = 8'h55; req_wdata = 8'h77;
    tick();
    reset = 1'b0; req_valid = 1'b0;
    check("rstwin_ready", 16'(req_ready), 16'd1);
    check("rstwin_mwr",   16'(memwrite), 16'd0);
    check("rstwin_addr",  16'(alu_result_address), 16'h00);
    tick();
    check("rstwin_idle",  16'(fsm_state), 16'd0);
    check("rstwin_mwr2",  16'(memwrite), 16'd0);
    check("rstwin_mem",   16'(mem[8'h55]), 16'hAA);

`ifdef LSU_BURST_EN
    // Load burst at 0xFE, three beats, wrapping to 0x00.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'hFE; req_len = 4'd2;
    tick();
    req_valid = 1'b0; req_len = 4'd0;
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < LAT; i++) begin
        check("bld_mrd",  16'(memread), 16'd1);
        check("bld_addr", 16'(alu_result_address), 16'(8'(8'hFE + b)));
        tick();
      end
      check("bld_rsp",   16'(rsp_valid), 16'd1);
      check("bld_rdata", 16'(rsp_rdata), 16'(~8'(8'hFE + b)));
      tick();
    end
    check("bld_ready", 16'(req_ready), 16'd1);

    // Store fill of 0x3C at 0x20..0x23.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h20;
    req_wdata = 8'h3C; req_len = 4'd3;
    tick();
    req_valid = 1'b0; req_len = 4'd0;
    for (int b = 0; b < 4; b++) begin
      check("bst_mwr",   16'(memwrite), 16'd1);
      check("bst_addr",  16'(alu_result_address), 16'(8'h20 + b));
      check("bst_wdata", 16'(write_data), 16'h3C);
      tick();
      check("bst_mwr_off", 16'(memwrite), 16'd0);
      tick();
    end
    check("bst_ready", 16'(req_ready), 16'd1);
    check("bst_mem23", 16'(mem[8'h23]), 16'h3C);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter MEM_LATENCY, default 1, SHALL set the number of read cycles memread is held before read data is captured (legal 1..15; 0 SHALL behave as 1).
REQ-002 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  core presents an access request.
REQ-005 req_write  input  1  1 = store, 0 = load.
REQ-006 req_addr  input  8  access address.
REQ-007 req_wdata  input  8  store data.
REQ-008 req_ready  output  1  unit accepts a request this cycle.
REQ-009 rsp_valid  output  1  one-cycle completion pulse.
REQ-010 rsp_rdata  output  8  load result, valid when rsp_valid=1 after a load.
REQ-011 alu_result_address  output  8  address to data memory.
REQ-012 write_data  output  8  data to data memory.
REQ-013 memread  output  1  memory read strobe.
REQ-014 memwrite  output  1  memory write strobe.
REQ-015 memory_to_register  output  1  memory mux select; SHALL be 1 exactly while memread=1.
REQ-016 mem_rdata  input  8  memory mux output (read data).

Function
REQ-017 The FSM SHALL have states IDLE, READ, WRITE and RESP.
REQ-018 In IDLE, req_ready SHALL be 1; in all other states it SHALL be 0.
REQ-019 A request SHALL be accepted only on an edge where req_valid=1 and req_ready=1; req_addr, req_wdata and req_write SHALL be latched on that edge.
REQ-020 req_valid while busy SHALL be ignored and SHALL NOT be queued.
REQ-021 For a load accepted at edge T, memread and memory_to_register SHALL be 1 for cycles T+1..T+MEM_LATENCY (READ), with alu_result_address held at the latched address.
REQ-022 The read-cycle counter SHALL be 4 bits; mem_rdata SHALL be captured into rsp_rdata on the edge ending the last READ cycle.
REQ-023 For a store accepted at edge T, memwrite SHALL be 1 for exactly cycle T+1 (WRITE), with write_data and alu_result_address held at the latched values.
REQ-024 RESP SHALL last one cycle with rsp_valid=1, then return to IDLE. Load-to-next-accept latency is MEM_LATENCY+2 cycles; store latency is 3 cycles.
REQ-025 rsp_rdata SHALL hold its value until the next load capture; stores SHALL NOT change it.
REQ-026 memread and memwrite SHALL never both be 1.
REQ-027 Outside READ and WRITE, memread, memwrite and memory_to_register SHALL be 0.

Reset
REQ-028 With reset=1 at an edge, the state SHALL become IDLE, the counters 0, and the outputs as follows: req_ready=1, rsp_valid=0, rsp_rdata=0x00, alu_result_address=0x00, write_data=0x00, memread=0, memwrite=0, memory_to_register=0.
REQ-029 Reset during any state, including mid-burst, SHALL abort the access with no further strobes and no rsp_valid.
REQ-030 When reset and req_valid are both 1, reset SHALL win and no request SHALL be accepted.

Configuration
REQ-031 When macro LSU_BURST_EN is defined, input req_len (4 bits) SHALL be added, giving beats = req_len+1 (1..16).
REQ-032 With LSU_BURST_EN, each beat SHALL repeat the REQ-021/023 sequence, and the address SHALL increment by 1 per beat, wrapping 0xFF to 0x00.
REQ-033 With LSU_BURST_EN, a store burst SHALL write req_wdata to every beat (fill).
REQ-034 With LSU_BURST_EN, each load beat SHALL produce its own RESP pulse; after the last beat the FSM SHALL return to IDLE.
REQ-035 Without LSU_BURST_EN, req_len SHALL be absent and every request SHALL be single-beat.

Verification
REQ-036 Reset, then a store of addr 0x10, data 0xA5: memwrite=1 for exactly one cycle with address 0x10 and data 0xA5, then a rsp_valid pulse; req_ready returns 3 cycles after accept.
REQ-037 With MEM_LATENCY=3, a load of 0x10 where memory returns 0xA5: memread=1 for 3 cycles, rsp_rdata=0xA5 with rsp_valid on cycle 4.
REQ-038 req_valid held high during a load: exactly one access occurs; the second request is accepted only after RESP.
REQ-039 reset asserted on the second READ cycle: memread=0 and req_ready=1 after that edge, with no rsp_valid.
REQ-040 With LSU_BURST_EN, a load of addr 0xFE with req_len=2: addresses 0xFE, 0xFF, 0x00 and three rsp_valid pulses.
REQ-041 With LSU_BURST_EN, a store fill of 0x3C at 0x20 with req_len=3: memwrite pulses at 0x20..0x23, all with data 0x3C.
